// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and default parameters for the round-robin arbiter controller
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational rotating-priority picker
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any_req,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDW-1:0]   win_id
);

    // Scan from the farthest offset down to the pointer so the closest set bit wins last
    always_comb begin
        int       idx;
        logic [IDW-1:0] idx_w;
        idx     = 0;
        idx_w   = '0;
        any_req = 1'b0;
        win_oh  = '0;
        win_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = IDW'(idx);
            if (req[idx_w]) begin
                any_req       = 1'b1;
                win_oh        = '0;
                win_oh[idx_w] = 1'b1;
                win_id        = idx_w;
            end
        end
    end

endmodule

// File: rtl/rr_arb_ctrl.sv
// rtl/rr_arb_ctrl.sv - round-robin start/done controller for a shared resource; RR_ARB_CTRL_TIMEOUT_EN adds the hold timeout
module rr_arb_ctrl
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             res_done,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             res_start,
    output logic             busy,
    output logic             timeout
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
    logic             timeout_q, timeout_d;

    logic             pick_any;
    logic [N_REQ-1:0] pick_oh;
    logic [IDW-1:0]   pick_id;
    logic             expire;

    rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any_req (pick_any),
        .win_oh  (pick_oh),
        .win_id  (pick_id)
    );

`ifdef RR_ARB_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    // Count BUSY cycles; expiry is judged on the incremented value so it lands on the MAX_HOLD-th BUSY cycle
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == GRANT) begin
            hold_cnt_d = '0;
        end else if (state_q == BUSY) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
        expire = (state_q == BUSY) && (hold_cnt_d == CW'(MAX_HOLD));
    end

    // Hold counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    localparam int UNUSED_MAX_HOLD = MAX_HOLD;

    assign expire = 1'b0;
`endif

    // Next-state and winner/pointer bookkeeping; done takes precedence over expiry
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_id;
                    grant_oh_d = pick_oh;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (res_done) begin
                    state_d = RELEASE;
                end else if (expire) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                ptr_d   = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = state_t'(2'bxx);
            end
        endcase
    end

    // State, pointer, latched winner and timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant     = (state_q == GRANT || state_q == BUSY) ? grant_oh_q : '0;
    assign grant_id  = grant_id_q;
    assign res_start = (state_q == GRANT);
    assign busy      = (state_q != IDLE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// tb/tb_rr_arb_ctrl.sv - directed self-checking bench for rr_arb_ctrl with a grant scoreboard
module tb_rr_arb_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       res_done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       res_start;
    logic       busy;
    logic       timeout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int sb[$];

    rr_arb_ctrl #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .res_done  (res_done),
        .grant     (grant),
        .grant_id  (grant_id),
        .res_start (res_start),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int c);
        bit ok;
        ok = 1'b0;
        c  = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (res_start) begin
                ok = 1'b1;
                c  = cyc;
            end else begin
                tick();
            end
        end
        check("start_seen", 32'(ok), 32'd1);
    endtask

    // Every start pulse must match the next expected winner
    always @(negedge clk) begin
        if (res_start) begin
            check("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                int e;
                logic [3:0] oh;
                e  = sb.pop_front();
                oh = 4'b0001 << e;
                check("sb_grant_id", 32'(grant_id), 32'(e));
                check("sb_grant", 32'(grant), 32'(oh));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int starts[5];

        reset    = 1'b1;
        req      = 4'b0000;
        res_done = 1'b0;
        repeat (3) tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_res_start", 32'(res_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // All requesting: 0,1,2,3,0 every 4 cycles
        for (int i = 0; i < 4; i++) sb.push_back(i);
        sb.push_back(0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(c);
            starts[i] = c;
            tick();
            res_done = 1'b1;
            if (i == 4) req = 4'b0000;
            tick();
            res_done = 1'b0;
            tick();
            tick();
        end
        for (int i = 1; i < 5; i++) check("rr_period", 32'(starts[i] - starts[i-1]), 32'd4);

        // Single requester 2, done on third BUSY cycle
        req = 4'b0100;
        sb.push_back(2);
        wait_start(c);
        check("s1_busy_grant", 32'(busy), 32'd1);
        tick();
        check("s1_b1_grant", 32'(grant), 32'h4);
        check("s1_b1_start", 32'(res_start), 32'd0);
        tick();
        tick();
        check("s1_b3_grant", 32'(grant), 32'h4);
        res_done = 1'b1;
        req      = 4'b0000;
        tick();
        res_done = 1'b0;
        check("s1_rel_grant", 32'(grant), 32'd0);
        check("s1_rel_busy", 32'(busy), 32'd1);
        tick();
        check("s1_idle_busy", 32'(busy), 32'd0);
        check("s1_idle_id", 32'(grant_id), 32'd2);

        // Wrap from pointer 3 to requester 0, then on to 1 despite req[0]
        req = 4'b0011;
        sb.push_back(0);
        sb.push_back(1);
        wait_start(c);
        tick();
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        tick();
        wait_start(c);
        check("wrap_second", 32'(grant), 32'h2);
        tick();
        res_done = 1'b1;
        req      = 4'b0000;
        tick();
        res_done = 1'b0;
        tick();

`ifdef RR_ARB_CTRL_TIMEOUT_EN
        // Timeout with no done at all
        req = 4'b1000;
        sb.push_back(3);
        wait_start(c);
        req = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("to_hold_grant", 32'(grant), 32'h8);
            check("to_hold_timeout", 32'(timeout), 32'd0);
        end
        tick();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_pulse_delay", 32'(cyc - c), 32'd9);
        check("to_rel_grant", 32'(grant), 32'd0);
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_idle_busy", 32'(busy), 32'd0);
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check("late_done_busy", 32'(busy), 32'd0);
        check("late_done_start", 32'(res_start), 32'd0);

        // Done and expiry on the same cycle
        req = 4'b0001;
        sb.push_back(0);
        wait_start(c);
        req = 4'b0000;
        repeat (8) tick();
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check("tie_timeout", 32'(timeout), 32'd0);
        check("tie_rel_busy", 32'(busy), 32'd1);
        check("tie_rel_grant", 32'(grant), 32'd0);
        tick();
`else
        // Without the timeout path BUSY waits indefinitely
        req = 4'b0001;
        sb.push_back(0);
        wait_start(c);
        req = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("nto_busy", 32'(busy), 32'd1);
            check("nto_grant", 32'(grant), 32'h1);
            check("nto_timeout", 32'(timeout), 32'd0);
        end
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check("nto_rel_timeout", 32'(timeout), 32'd0);
        check("nto_rel_grant", 32'(grant), 32'd0);
        tick();
`endif

        // Asynchronous reset during BUSY
        req = 4'b0010;
        sb.push_back(1);
        wait_start(c);
        tick();
        check("prerst_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_start", 32'(res_start), 32'd0);
        check("arst_grant_id", 32'(grant_id), 32'd0);
        req = 4'b1000;
        tick();
        tick();
        sb.push_back(3);
        reset = 1'b0;
        wait_start(c);
        check("post_rst_id", 32'(grant_id), 32'd3);
        tick();
        res_done = 1'b1;
        req      = 4'b0000;
        tick();
        res_done = 1'b0;
        tick();
        check("final_busy", 32'(busy), 32'd0);
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arb_ctrl.md
# rr_arb_ctrl

Round-robin controller that shares one single-transaction resource (a start/done sequencer such as the small Moore control FSMs in this codebase) among N_REQ requesters. It picks one requester, holds a one-hot grant, issues a one-cycle start pulse to the resource, and waits for done. It then releases the grant and rotates priority. It sits between the requesting agents and the shared resource.

## Interface
- N_REQ, 4, number of requesters (2..16)
- MAX_HOLD, 8, timeout limit in BUSY cycles (≥1; only used with timeout compiled in)
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  N_REQ  level request per requester
- res_done  input  1  resource completion pulse
- grant  output  N_REQ  one-hot grant, else all-zero
- grant_id  output  $clog2(N_REQ)  index of current or last winner
- res_start  output  1  one-cycle start pulse to resource
- busy  output  1  high whenever state ≠ IDLE
- timeout  output  1  one-cycle pulse when a transaction is aborted

## Operation
- States: IDLE, GRANT, BUSY, RELEASE. All outputs are Moore outputs, decoded or registered from state.
- IDLE: if any req bit is set, latch the winner and go to GRANT; otherwise stay in IDLE.
- GRANT: grant[winner]=1 and res_start=1 for exactly this cycle; always go to BUSY.
- BUSY: grant is held. res_done=1 → RELEASE. Timeout expiry → RELEASE with timeout flagged.
- RELEASE: grant=0. Priority pointer = (winner+1) mod N_REQ. Go to IDLE.
- Winner: first set req bit, searching upward from the pointer with wrap-around. Pointer resets to 0, so requester 0 has first priority.
- No preemption. If req drops after the grant, the grant is still held until done or timeout.
- res_done is ignored in IDLE, GRANT and RELEASE.
- Unreachable state encodings drive next state to all-x so simulation flags them.
- Reset values: grant=0, grant_id=0, res_start=0, busy=0, timeout=0, state=IDLE, pointer=0, hold counter=0.
- Reset mid-transaction: everything returns to reset values immediately. The resource receives no further pulse.

## Timing
- req seen in IDLE at cycle T → GRANT at T+1 (grant and res_start high) → BUSY from T+2.
- res_done in BUSY at cycle D → RELEASE at D+1 → IDLE at D+2. The next grant comes no earlier than D+3.
- Minimum period is 4 cycles per transaction, when done arrives on the first BUSY cycle.
- grant_id is valid from T+1 and held through IDLE until the next winner.
- Hold counter: cleared in GRANT, incremented every BUSY cycle, width $clog2(MAX_HOLD+1).
- Timeout fires when the counter equals MAX_HOLD without done, i.e. on the MAX_HOLD-th BUSY cycle. The timeout pulse is asserted during RELEASE.
- If done and expiry occur in the same cycle, done wins and no timeout pulse is issued.

## Configuration
- RR_ARB_CTRL_TIMEOUT_EN defined: hold counter and timeout path are present, as described above.
- Not defined: no counter logic. BUSY waits indefinitely for res_done. timeout is tied to 0. MAX_HOLD is ignored.

## Structure
- Package rr_arb_pkg holds:
  - the state enum typedef (state_t: IDLE=0, GRANT, BUSY, RELEASE; 2-bit, plus x-value for illegal)
  - the default N_REQ and MAX_HOLD constants.
- Sub-module rr_arb_pick: combinational rotating-priority picker. Inputs are req and pointer; outputs are any_req, a one-hot winner and the winner index. Instantiated once.

## Test plan
- Single requester: req=4'b0100 held; done 3 cycles after start → grant=4'b0100 for GRANT plus 3 BUSY cycles, one res_start pulse, pointer→3, busy drops 2 cycles after done.
- All requesting: req=4'b1111 constant, done on first BUSY cycle → grants 0,1,2,3,0 in order, each 4 cycles apart.
- Wrap and skip: pointer=3 and req=4'b0011 → grant to 0. Next grant goes to 1 even if req[0] is still high.
- Timeout, with TIMEOUT_EN and MAX_HOLD=8, no done → timeout pulses once, 9 cycles after res_start, grant cleared. A late done arriving in IDLE is ignored.
- Done and expiry together on cycle 8 of BUSY → RELEASE with timeout=0.
- Reset asserted during BUSY → grant, busy and res_start go to 0 asynchronously. After release, req=4'b1000 is granted from pointer 0 with a fresh start pulse.
